// File: rtl/echo_arb_pkg.sv
// Shared definitions for the echo arbiter slice: tag FIFO depth,
// tag type identifying which requester issued a say, and pointer width.
package echo_arb_pkg;

    // Maximum number of says that may be outstanding at the shared echo.
    // Must be a power of two and at least 2 so pointers wrap for free.
    localparam int TAG_DEPTH = 4;

    // Width of the FIFO read/write pointers for the default depth.
    localparam int PTR_W = $clog2(TAG_DEPTH);

    // One bit is enough to name either of the two requesters.
    typedef logic tag_t;

    localparam tag_t TAG_REQ0 = 1'b0;
    localparam tag_t TAG_REQ1 = 1'b1;

endpackage

// File: rtl/echo_tag_fifo.sv
// Tag FIFO: remembers which requester issued each outstanding say so
// that responses coming back from the echo can be routed in issue order.
// The head tag is read combinationally so routing happens in the same
// cycle the response is presented.
module echo_tag_fifo
    import echo_arb_pkg::*;
#(
    parameter int DEPTH = TAG_DEPTH
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       push,
    input  tag_t                       push_tag,
    input  logic                       pop,
    output tag_t                       head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW:0]   CNT_ONE   = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_DEPTH = (PW + 1)'(DEPTH);

    tag_t          mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;
    logic [PW:0]   count_next;
    logic          push_ok;
    logic          pop_ok;

    // Never overwrite a live entry or pop a stale one, whatever the caller does.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign full  = (count_reg == CNT_DEPTH);
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign head  = mem_reg[rd_ptr_reg];

    // Tag storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_tag;
        end
    end

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // Pointers and count; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/echo_arbiter.sv
// Two-requester round-robin arbiter in front of a shared echo service.
// Says are forwarded combinationally; the issuing requester is queued in
// a tag FIFO so each response is routed back to whoever asked, in order.
module echo_arbiter
    import echo_arb_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        say0__ENA,
    input  logic [31:0] say0_v,
    output logic        say0__RDY,
    input  logic        say1__ENA,
    input  logic [31:0] say1_v,
    output logic        say1__RDY,
    output logic        echo_say__ENA,
    output logic [31:0] echo_say_v,
    input  logic        echo_say__RDY,
    input  logic        heard__ENA,
    input  logic [31:0] heard_v,
    output logic        heard__RDY,
    output logic        ind0_heard__ENA,
    output logic [31:0] ind0_heard_v,
    input  logic        ind0_heard__RDY,
    output logic        ind1_heard__ENA,
    output logic [31:0] ind1_heard_v,
    input  logic        ind1_heard__RDY
);

    tag_t                 prio_reg;
    tag_t                 prio_next;
    tag_t                 head;
    logic                 full;
    logic                 empty;
    logic [PTR_W:0]       count;
    logic                 base;
    logic                 pop;
    logic [1:0]           say_ena;
    logic [1:0]           say_rdy;
    logic [1:0]           accept;
    logic [1:0]           ind_rdy;
    logic [1:0]           ind_ena;

    assign say_ena = {say1__ENA, say0__ENA};
    assign ind_rdy = {ind1_heard__RDY, ind0_heard__RDY};

    // A say may only go out when the echo is ready and a tag slot is free;
    // a pop in the same cycle does not free a slot early.
    assign base = echo_say__RDY & ~full & nRST;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            // Requester wins if it holds priority or the other one is idle.
            assign say_rdy[gi] = base & ((prio_reg == tag_t'(gi)) | ~say_ena[1 - gi]);
            assign accept[gi]  = say_ena[gi] & say_rdy[gi];
            // Only the requester named by the head tag sees the response.
            assign ind_ena[gi] = heard__ENA & heard__RDY & (head == tag_t'(gi));
        end
    endgenerate

    assign say0__RDY = say_rdy[0];
    assign say1__RDY = say_rdy[1];

    assign echo_say__ENA = accept[0] | accept[1];
    assign echo_say_v    = accept[1] ? say1_v : say0_v;

    // Responses wait at the echo until a tag is outstanding and its owner is ready.
    assign heard__RDY = nRST & ~empty & ind_rdy[head];
    assign pop        = heard__ENA & heard__RDY;

    assign ind0_heard__ENA = ind_ena[0];
    assign ind1_heard__ENA = ind_ena[1];
    assign ind0_heard_v    = heard_v;
    assign ind1_heard_v    = heard_v;

    // Round-robin: after serving one requester, hand priority to the other.
    always_comb begin
        prio_next = prio_reg;
        if (accept[0]) begin
            prio_next = TAG_REQ1;
        end else if (accept[1]) begin
            prio_next = TAG_REQ0;
        end
    end

    // Priority pointer register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            prio_reg <= TAG_REQ0;
        end else begin
            prio_reg <= prio_next;
        end
    end

    echo_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .CLK      (CLK),
        .nRST     (nRST),
        .push     (echo_say__ENA),
        .push_tag (accept[1] ? TAG_REQ1 : TAG_REQ0),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // Occupancy is exposed by the FIFO for debug; the arbiter only needs full/empty.
    logic count_unused;
    assign count_unused = ^count;

endmodule

// File: tb/tb_echo_arbiter.sv
// Self-checking bench for echo_arbiter: directed scenarios plus a random
// run, all compared against a queue-based model of outstanding says.
module tb_echo_arbiter;
    import echo_arb_pkg::*;

    localparam int DEPTH = TAG_DEPTH;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        say0_ena, say1_ena, echo_rdy, heard_ena, ind0_rdy, ind1_rdy;
    logic [31:0] say0_v, say1_v, heard_v;
    logic        say0_rdy, say1_rdy, echo_ena, heard_rdy, ind0_ena, ind1_ena;
    logic [31:0] echo_v, ind0_v, ind1_v;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: queue of requester ids awaiting a response, plus whose turn it is.
    int mq[$];
    int mprio;
    bit m_acc0, m_acc1, m_pop;
    bit e_rdy0, e_rdy1, e_eena, e_hrdy, e_ind0, e_ind1;
    logic [31:0] e_ev;

    always #5 CLK = ~CLK;

    echo_arbiter dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .say0__ENA       (say0_ena),
        .say0_v          (say0_v),
        .say0__RDY       (say0_rdy),
        .say1__ENA       (say1_ena),
        .say1_v          (say1_v),
        .say1__RDY       (say1_rdy),
        .echo_say__ENA   (echo_ena),
        .echo_say_v      (echo_v),
        .echo_say__RDY   (echo_rdy),
        .heard__ENA      (heard_ena),
        .heard_v         (heard_v),
        .heard__RDY      (heard_rdy),
        .ind0_heard__ENA (ind0_ena),
        .ind0_heard_v    (ind0_v),
        .ind0_heard__RDY (ind0_rdy),
        .ind1_heard__ENA (ind1_ena),
        .ind1_heard_v    (ind1_v),
        .ind1_heard__RDY (ind1_rdy)
    );

    // Let inputs settle, then derive what the outputs must be this cycle.
    task automatic settle();
        bit base;
        int h;
        #1;
        base   = nRST && echo_rdy && (mq.size() < DEPTH);
        e_rdy0 = base && (mprio == 0 || !say1_ena);
        e_rdy1 = base && (mprio == 1 || !say0_ena);
        m_acc0 = say0_ena && e_rdy0;
        m_acc1 = say1_ena && e_rdy1;
        e_eena = m_acc0 || m_acc1;
        e_ev   = m_acc1 ? say1_v : say0_v;
        h      = (mq.size() > 0) ? mq[0] : -1;
        e_hrdy = nRST && (h >= 0) && ((h == 0) ? ind0_rdy : ind1_rdy);
        m_pop  = heard_ena && e_hrdy;
        e_ind0 = m_pop && (h == 0);
        e_ind1 = m_pop && (h == 1);
    endtask

    // Clock edge: apply this cycle's accepted say / routed response to the model.
    task automatic advance();
        @(posedge CLK);
        if (!nRST) begin
            mq.delete();
            mprio = 0;
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (m_acc0) begin
                mq.push_back(0);
                mprio = 1;
            end else if (m_acc1) begin
                mq.push_back(1);
                mprio = 0;
            end
        end
        @(negedge CLK);
    endtask

    task automatic idle();
        say0_ena = 0; say1_ena = 0; heard_ena = 0;
        echo_rdy = 1; ind0_rdy = 1; ind1_rdy = 1;
        say0_v = '0; say1_v = '0; heard_v = '0;
    endtask

    task automatic do_reset();
        idle();
        nRST = 0;
        settle();
        advance();
        nRST = 1;
    endtask

    task automatic drain();
        int guard = 0;
        idle();
        heard_ena = 1;
        while (mq.size() > 0 && guard < 20) begin
            heard_v = $urandom;
            settle();
            advance();
            guard++;
        end
        heard_ena = 0;
        n_checks++;
        if (mq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d tags left, expected 0", mq.size());
        end
    endtask

    task automatic test_reset();
        idle();
        nRST = 0;
        say0_ena = 1; say1_ena = 1; heard_ena = 1;
        settle();
        n_checks++;
        if ({say0_rdy, say1_rdy, heard_rdy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_rdy: got %b expected 000", {say0_rdy, say1_rdy, heard_rdy});
        end
        n_checks++;
        if ({echo_ena, ind0_ena, ind1_ena} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ena: got %b expected 000", {echo_ena, ind0_ena, ind1_ena});
        end
        advance();
        nRST = 1;
        idle();
        heard_ena = 1;
        settle();
        n_checks++;
        if (heard_rdy !== 1'b0 || say0_rdy !== 1'b1 || say1_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset: heard_rdy=%b say0_rdy=%b say1_rdy=%b expected 0 1 1",
                     heard_rdy, say0_rdy, say1_rdy);
        end
        advance();
        $display("test_reset done");
    endtask

    task automatic test_alternate();
        do_reset();
        say0_ena = 1; say1_ena = 1; say0_v = 32'h11; say1_v = 32'h22;
        for (int k = 0; k < DEPTH; k++) begin
            settle();
            n_checks++;
            if (echo_ena !== 1'b1 || echo_v !== ((k % 2) ? 32'h22 : 32'h11)) begin
                n_fail++;
                $display("FAIL alternate[%0d]: ena=%b v=%h expected 1 %h",
                         k, echo_ena, echo_v, (k % 2) ? 32'h22 : 32'h11);
            end
            advance();
        end
        drain();
        $display("test_alternate done");
    endtask

    task automatic test_work_conserving();
        idle();
        say1_ena = 1; heard_ena = 1;
        for (int k = 0; k < 6; k++) begin
            say1_v = 32'h100 + k;
            settle();
            n_checks++;
            if (say1_rdy !== 1'b1 || echo_ena !== 1'b1 || echo_v !== 32'h100 + k) begin
                n_fail++;
                $display("FAIL work_conserving[%0d]: rdy=%b ena=%b v=%h expected 1 1 %h",
                         k, say1_rdy, echo_ena, echo_v, 32'h100 + k);
            end
            advance();
        end
        drain();
        $display("test_work_conserving done");
    endtask

    task automatic test_full();
        do_reset();
        say0_ena = 1;
        for (int k = 0; k < DEPTH; k++) begin
            settle();
            advance();
        end
        say1_ena = 1;
        settle();
        n_checks++;
        if (say0_rdy !== 1'b0 || say1_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_block: say0_rdy=%b say1_rdy=%b expected 0 0", say0_rdy, say1_rdy);
        end
        say1_ena = 0; heard_ena = 1;
        settle();
        n_checks++;
        if (say0_rdy !== 1'b0 || echo_ena !== 1'b0 || ind0_ena !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pop_no_bypass: rdy=%b echo_ena=%b ind0_ena=%b expected 0 0 1",
                     say0_rdy, echo_ena, ind0_ena);
        end
        advance();
        say0_ena = 0; heard_ena = 0;
        settle();
        n_checks++;
        if (say0_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL after_pop_rdy: got %b expected 1", say0_rdy);
        end
        heard_ena = 1;
        settle();
        advance();
        say0_ena = 1;
        settle();
        n_checks++;
        if (echo_ena !== 1'b1 || ind0_ena !== 1'b1) begin
            n_fail++;
            $display("FAIL push_pop: echo_ena=%b ind0_ena=%b expected 1 1", echo_ena, ind0_ena);
        end
        advance();
        heard_ena = 0;
        for (int k = 0; k < 3; k++) begin
            settle();
            n_checks++;
            if (say0_rdy !== (k < 2)) begin
                n_fail++;
                $display("FAIL count_after_push_pop[%0d]: rdy=%b expected %b", k, say0_rdy, k < 2);
            end
            advance();
        end
        drain();
        $display("test_full done");
    endtask

    task automatic test_order();
        logic [31:0] sv [3];
        logic [31:0] rv [3];
        int dst [3];
        sv = '{32'hA, 32'hB, 32'hC};
        rv = '{32'h1, 32'h2, 32'h3};
        dst = '{0, 1, 0};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            say0_ena = (dst[k] == 0); say1_ena = (dst[k] == 1);
            say0_v = sv[k]; say1_v = sv[k];
            settle();
            n_checks++;
            if (echo_ena !== 1'b1 || echo_v !== sv[k]) begin
                n_fail++;
                $display("FAIL order_say[%0d]: ena=%b v=%h expected 1 %h", k, echo_ena, echo_v, sv[k]);
            end
            advance();
        end
        idle();
        heard_ena = 1;
        for (int k = 0; k < 3; k++) begin
            heard_v = rv[k];
            settle();
            n_checks++;
            if (ind0_ena !== (dst[k] == 0) || ind1_ena !== (dst[k] == 1) ||
                (dst[k] == 0 ? ind0_v : ind1_v) !== rv[k]) begin
                n_fail++;
                $display("FAIL order_heard[%0d]: ind0=%b ind1=%b v0=%h v1=%h expected dest %0d v %h",
                         k, ind0_ena, ind1_ena, ind0_v, ind1_v, dst[k], rv[k]);
            end
            advance();
        end
        heard_ena = 0;
        $display("test_order done");
    endtask

    task automatic test_head_block();
        do_reset();
        say1_ena = 1;
        settle();
        advance();
        idle();
        heard_ena = 1; ind1_rdy = 0; heard_v = 32'h55;
        settle();
        n_checks++;
        if (heard_rdy !== 1'b0 || ind0_ena !== 1'b0 || ind1_ena !== 1'b0) begin
            n_fail++;
            $display("FAIL head_block: heard_rdy=%b ind0=%b ind1=%b expected 0 0 0",
                     heard_rdy, ind0_ena, ind1_ena);
        end
        advance();
        ind1_rdy = 1;
        settle();
        n_checks++;
        if (heard_rdy !== 1'b1 || ind1_ena !== 1'b1 || ind0_ena !== 1'b0 || ind1_v !== 32'h55) begin
            n_fail++;
            $display("FAIL head_release: heard_rdy=%b ind1=%b ind0=%b v=%h expected 1 1 0 55",
                     heard_rdy, ind1_ena, ind0_ena, ind1_v);
        end
        advance();
        settle();
        n_checks++;
        if (heard_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_hold: heard_rdy=%b expected 0", heard_rdy);
        end
        advance();
        heard_ena = 0;
        $display("test_head_block done");
    endtask

    task automatic test_mid_reset();
        do_reset();
        say0_ena = 1;
        settle(); advance();
        settle(); advance();
        say0_ena = 0; heard_ena = 1; nRST = 0;
        settle();
        n_checks++;
        if (heard_rdy !== 1'b0 || ind0_ena !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_low: heard_rdy=%b ind0=%b expected 0 0", heard_rdy, ind0_ena);
        end
        advance();
        nRST = 1;
        settle();
        n_checks++;
        if (heard_rdy !== 1'b0 || ind0_ena !== 1'b0 || ind1_ena !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_discard: heard_rdy=%b ind0=%b ind1=%b expected 0 0 0",
                     heard_rdy, ind0_ena, ind1_ena);
        end
        advance();
        heard_ena = 0;
        $display("test_mid_reset done");
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            nRST      = ($urandom_range(0, 39) != 0);
            say0_ena  = $urandom_range(0, 1);
            say1_ena  = $urandom_range(0, 1);
            say0_v    = $urandom;
            say1_v    = $urandom;
            echo_rdy  = ($urandom_range(0, 3) != 0);
            heard_ena = $urandom_range(0, 1);
            heard_v   = $urandom;
            ind0_rdy  = ($urandom_range(0, 3) != 0);
            ind1_rdy  = ($urandom_range(0, 3) != 0);
            settle();
            n_checks++;
            if (say0_rdy !== e_rdy0 || say1_rdy !== e_rdy1) begin
                n_fail++;
                $display("FAIL rnd_say_rdy[%0d]: got %b%b expected %b%b", k, say0_rdy, say1_rdy, e_rdy0, e_rdy1);
            end
            n_checks++;
            if (echo_ena !== e_eena || (e_eena && echo_v !== e_ev)) begin
                n_fail++;
                $display("FAIL rnd_echo[%0d]: ena=%b v=%h expected %b %h", k, echo_ena, echo_v, e_eena, e_ev);
            end
            n_checks++;
            if (heard_rdy !== e_hrdy || ind0_ena !== e_ind0 || ind1_ena !== e_ind1) begin
                n_fail++;
                $display("FAIL rnd_heard[%0d]: rdy=%b ind=%b%b expected %b %b%b",
                         k, heard_rdy, ind0_ena, ind1_ena, e_hrdy, e_ind0, e_ind1);
            end
            n_checks++;
            if (ind0_v !== heard_v || ind1_v !== heard_v) begin
                n_fail++;
                $display("FAIL rnd_heard_v[%0d]: v0=%h v1=%h expected %h", k, ind0_v, ind1_v, heard_v);
            end
            advance();
        end
        nRST = 1;
        drain();
        $display("test_random done");
    endtask

    initial begin
        mprio = 0;
        idle();
        nRST = 0;
        @(negedge CLK);
        test_reset();
        test_alternate();
        test_work_conserving();
        test_full();
        test_order();
        test_head_block();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/echo_arbiter.md
ECHO_ARBITER -- requirements
Module: echo_arbiter

Interface
REQ-001 TAG_DEPTH, 4, tag FIFO entries (max outstanding says); power of 2, >=2.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 nRST  input  1  reset, synchronous, active-low.
REQ-004 say0__ENA / say1__ENA  input  1  requester i issues say.
REQ-005 say0_v / say1_v  input  32  requester i payload.
REQ-006 say0__RDY / say1__RDY  output  1  requester i may fire this cycle.
REQ-007 echo$say__ENA  output  1  forwarded say to shared echo.
REQ-008 echo$say_v  output  32  granted payload.
REQ-009 echo$say__RDY  input  1  echo can accept say.
REQ-010 heard__ENA  input  1  echo delivers response.
REQ-011 heard_v  input  32  response payload.
REQ-012 heard__RDY  output  1  arbiter can route response.
REQ-013 ind0$heard__ENA / ind1$heard__ENA  output  1  response to requester i.
REQ-014 ind0_heard_v / ind1_heard_v  output  32  response payload to requester i.
REQ-015 ind0$heard__RDY / ind1$heard__RDY  input  1  requester i can take response.

Function
REQ-016 base = echo$say__RDY & (count < TAG_DEPTH) & nRST; no full bypass even when pop occurs same cycle.
REQ-017 say_i__RDY = base & (prio==i | !say_j__ENA), j = other requester; at most one say fires per cycle.
REQ-018 Accept_i = say_i__ENA & say_i__RDY; echo$say__ENA = Accept_0 | Accept_1, combinational, zero latency.
REQ-019 echo$say_v = say1_v when Accept_1, else say0_v.
REQ-020 prio: 1-bit round-robin pointer; after Accept_i, prio <= j next cycle; unchanged when no accept.
REQ-021 On each accept, push tag i at wr_ptr; wr_ptr wraps TAG_DEPTH-1 -> 0.
REQ-022 head = tag at rd_ptr; heard__RDY = nRST & (count>0) & ind_head$heard__RDY.
REQ-023 ind_i$heard__ENA = heard__ENA & heard__RDY & (head==i); other requester's ENA low.
REQ-024 ind0_heard_v = ind1_heard_v = heard_v, unregistered.
REQ-025 Pop on routed response; rd_ptr wraps like wr_ptr.
REQ-026 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-027 Empty (count 0): heard__RDY low; response held off by echo, never dropped or misrouted.
REQ-028 Responses returned to requesters in exact issue order across both requesters.

Reset
REQ-029 nRST low at rising edge: prio=0, count=0, wr_ptr=0, rd_ptr=0; tag storage need not clear.
REQ-030 While nRST low: all __RDY outputs and all __ENA outputs low.
REQ-031 Reset mid-operation discards outstanding tags; responses arriving afterwards are blocked until new says issued.

Structure
REQ-032 Shared package echo_arb_pkg holds TAG_DEPTH default, tag type (1 bit), pointer width log2(TAG_DEPTH).
REQ-033 Tag storage, pointers and count in one sub-module echo_tag_fifo (push/pop/full/empty/head); arbitration in top level.

Verification
REQ-034 Reset, both say ENA high, say0_v=0x11, say1_v=0x22, echo$say__RDY=1 -> cycle0 forwards 0x11, cycle1 0x22, alternating thereafter.
REQ-035 Only say1 active 6 cycles, echo ready -> 6 consecutive accepts, no idle cycles (work-conserving).
REQ-036 4 says accepted, no responses -> count=4, both say__RDY low; one response routed -> say__RDY rises next cycle.
REQ-037 Issue say0(0xA), say1(0xB), say0(0xC); echo returns 0x1,0x2,0x3 -> ind0 gets 0x1, ind1 gets 0x2, ind0 gets 0x3.
REQ-038 Head tag=1, ind1$heard__RDY=0, heard__ENA=1 -> heard__RDY low, no ind ENA; raise ind1 ready -> delivered that cycle.
REQ-039 count=4, same cycle one response and say0__ENA -> say blocked, count=3 next cycle; count=2 with push+pop -> count stays 2.
